mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Drives a variable-latency data memory over a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register that feeds writeback and forwarding.
- Handles misaligned accesses and memory timeouts by converting the instruction into a bubble and flagging an error.

Parameters:
TIMEOUT_CYCLES, 16, cycles in BUSY without ack before the access is abandoned; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  asynchronous, active-low reset
MemtoReg_i  input  1  from EX/MEM: writeback selects memory data
RegWrite_i  input  1  from EX/MEM: instruction writes rd
MemRead_i  input  1  from EX/MEM: load
MemWrite_i  input  1  from EX/MEM: store
Result_i  input  32  from EX/MEM: ALU result / byte address
Data_i  input  32  from EX/MEM: store data
RD_i  input  5  from EX/MEM: destination register
stall_o  output  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
mem_req_o  output  1  memory request
mem_we_o  output  1  1 = write, 0 = read
mem_addr_o  output  32  word-aligned address
mem_wdata_o  output  32  store data
mem_ack_i  input  1  memory completes the access this cycle
mem_rdata_i  input  32  load data, valid when mem_ack_i = 1
err_o  output  1  one-cycle pulse on misaligned access or timeout
MemtoReg_o  output  1  MEM/WB register
RegWrite_o  output  1  MEM/WB register
ReadData_o  output  32  MEM/WB register: loaded word
Result_o  output  32  MEM/WB register: ALU result
RD_o  output  5  MEM/WB register: destination register

Behaviour:
- Definitions: memop = MemRead_i | MemWrite_i. A load takes priority if both are set; it is treated as a read.
- Reset (rst_i = 0, asynchronous):
  - state = IDLE, counter = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, err_o = 0.
  - All MEM/WB outputs = 0.
  - An outstanding access is abandoned. The memory must tolerate a dropped req.
- FSM states: IDLE, BUSY.
- IDLE:
  - No memop: stall_o = 0. MEM/WB loads the inputs on the edge with ReadData_o = 0. Latency is 1 cycle.
  - memop with Result_i[1:0] != 0 (misaligned):
    - No request is issued and stall_o = 0.
    - err_o pulses on the next cycle.
    - MEM/WB loads a bubble: RegWrite_o = 0, MemtoReg_o = 0, RD_o = 0, Result_o = Result_i.
  - memop, aligned: stall_o = 1 combinationally. On the edge:
    - latch mem_addr_o = Result_i, mem_wdata_o = Data_i, mem_we_o = ~MemRead_i;
    - latch MemtoReg/RegWrite/RD/Result internally;
    - set mem_req_o = 1, counter = 0, state → BUSY;
    - MEM/WB loads a bubble.
- BUSY:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until the ack or timeout cycle.
  - stall_o = ~mem_ack_i & ~timeout, where timeout = (TIMEOUT_CYCLES != 0) & (counter == TIMEOUT_CYCLES - 1).
  - mem_ack_i = 1:
    - MEM/WB loads the latched fields; ReadData_o = mem_rdata_i for a read, 0 for a write.
    - mem_req_o → 0, state → IDLE.
    - EX/MEM advances on the same edge, since stall_o = 0.
  - Timeout without ack:
    - mem_req_o → 0, err_o pulses, MEM/WB loads a bubble, state → IDLE.
  - Otherwise: counter increments and MEM/WB loads a bubble.
- Simultaneous ack and timeout: the ack wins and there is no error.
- mem_ack_i in IDLE is ignored.
- Minimum memop cost: 1 stall cycle, when the ack arrives in the first BUSY cycle.
- Stall rule: on every edge where stall_o = 1, MEM/WB loads a bubble, so writeback never repeats an instruction.
- EX/MEM contract: inputs must be held constant while stall_o = 1. The unit reads them only in IDLE.

Test Plan:
1. ALU op (RegWrite = 1, RD = 5, Result = 0x0000_00AA, no memop) → next cycle RegWrite_o = 1, RD_o = 5, Result_o = 0xAA, stall_o never 1, mem_req_o = 0.
2. Load at 0x100, memory acks 3 cycles after req with rdata = 0xDEADBEEF:
   - stall_o = 1 for 4 cycles;
   - mem_addr_o = 0x100 and mem_we_o = 0 stable throughout;
   - then ReadData_o = 0xDEADBEEF, MemtoReg_o = 1;
   - exactly one non-bubble MEM/WB entry.
3. Store 0x12345678 to 0x40, ack in the first BUSY cycle → mem_we_o = 1, mem_wdata_o = 0x12345678, exactly 1 stall cycle, RegWrite_o = 0.
4. Load at 0x102 → no mem_req_o, err_o = 1 for one cycle, RegWrite_o = 0, no stall.
5. TIMEOUT_CYCLES = 4, no ack ever:
   - mem_req_o high for 4 cycles then low;
   - err_o pulses once and stall releases;
   - the next instruction proceeds normally.
   - Repeat with the ack arriving on the timeout cycle → no err_o, data captured.
6. Assert rst_i = 0 mid-BUSY → mem_req_o drops immediately (asynchronously), all outputs 0, state IDLE after release; a following load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM stage: drives a variable-latency data memory over req/ack, stalls upstream
// while an access is outstanding, and holds the MEM/WB pipeline register.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Result_i,
  input  logic [31:0] Data_i,
  input  logic [4:0]  RD_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] Result_o,
  output logic [4:0]  RD_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              err_reg, err_next;
  // instruction fields parked while the access is in flight
  logic              lat_mtr_reg, lat_mtr_next;
  logic              lat_rw_reg, lat_rw_next;
  logic [4:0]        lat_rd_reg, lat_rd_next;
  logic [31:0]       lat_res_reg, lat_res_next;
  logic              wb_mtr_reg, wb_mtr_next;
  logic              wb_rw_reg, wb_rw_next;
  logic [4:0]        wb_rd_reg, wb_rd_next;
  logic [31:0]       wb_res_reg, wb_res_next;
  logic [31:0]       wb_rdata_reg, wb_rdata_next;

  logic memop, misaligned, timeout;

  assign memop      = MemRead_i | MemWrite_i;
  assign misaligned = (Result_i[1:0] != 2'b00);
  assign timeout    = TO_EN && (cnt_reg == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
      lat_mtr_reg  <= 1'b0;
      lat_rw_reg   <= 1'b0;
      lat_rd_reg   <= '0;
      lat_res_reg  <= '0;
      wb_mtr_reg   <= 1'b0;
      wb_rw_reg    <= 1'b0;
      wb_rd_reg    <= '0;
      wb_res_reg   <= '0;
      wb_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      err_reg      <= err_next;
      lat_mtr_reg  <= lat_mtr_next;
      lat_rw_reg   <= lat_rw_next;
      lat_rd_reg   <= lat_rd_next;
      lat_res_reg  <= lat_res_next;
      wb_mtr_reg   <= wb_mtr_next;
      wb_rw_reg    <= wb_rw_next;
      wb_rd_reg    <= wb_rd_next;
      wb_res_reg   <= wb_res_next;
      wb_rdata_reg <= wb_rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    lat_mtr_next  = lat_mtr_reg;
    lat_rw_next   = lat_rw_reg;
    lat_rd_next   = lat_rd_reg;
    lat_res_next  = lat_res_reg;
    err_next      = 1'b0;
    // MEM/WB defaults to a bubble; only retiring instructions overwrite it
    wb_mtr_next   = 1'b0;
    wb_rw_next    = 1'b0;
    wb_rd_next    = '0;
    wb_res_next   = '0;
    wb_rdata_next = '0;
    stall_o       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!memop) begin
          wb_mtr_next = MemtoReg_i;
          wb_rw_next  = RegWrite_i;
          wb_rd_next  = RD_i;
          wb_res_next = Result_i;
        end else if (misaligned) begin
          err_next    = 1'b1;
          wb_res_next = Result_i;
        end else begin
          stall_o      = 1'b1;
          req_next     = 1'b1;
          we_next      = ~MemRead_i;
          addr_next    = Result_i;
          wdata_next   = Data_i;
          lat_mtr_next = MemtoReg_i;
          lat_rw_next  = RegWrite_i;
          lat_rd_next  = RD_i;
          lat_res_next = Result_i;
          cnt_next     = '0;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          req_next      = 1'b0;
          wb_mtr_next   = lat_mtr_reg;
          wb_rw_next    = lat_rw_reg;
          wb_rd_next    = lat_rd_reg;
          wb_res_next   = lat_res_reg;
          wb_rdata_next = we_reg ? 32'h0 : mem_rdata_i;
          state_next    = IDLE;
        end else if (timeout) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          stall_o  = 1'b1;
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req_o   = req_reg;
  assign mem_we_o    = we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign err_o       = err_reg;
  assign MemtoReg_o  = wb_mtr_reg;
  assign RegWrite_o  = wb_rw_reg;
  assign RD_o        = wb_rd_reg;
  assign Result_o    = wb_res_reg;
  assign ReadData_o  = wb_rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected MEM/WB entries,
// a monitor pops them when an instruction retires; a memory model checks the bus.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        MemtoReg_i = 1'b0, RegWrite_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
  logic [31:0] Result_i = '0, Data_i = '0;
  logic [4:0]  RD_i = '0;
  logic        stall_o, mem_req_o, mem_we_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        MemtoReg_o, RegWrite_o;
  logic [31:0] ReadData_o, Result_o;
  logic [4:0]  RD_o;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .Result_i(Result_i), .Data_i(Data_i), .RD_i(RD_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .ReadData_o(ReadData_o),
    .Result_o(Result_o), .RD_o(RD_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        mtr;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] rdata;
    logic        err;
    logic        chk_res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic tb_valid = 1'b0;

  // memory model controls
  int          ack_delay = -1;
  logic [31:0] ack_data = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;
  int          busy_cnt = 0;
  int          req_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic mtr, input logic rw, input logic [4:0] rd,
                              input logic [31:0] res, input logic [31:0] rdata,
                              input logic err, input logic chk_res);
    exp_t e;
    e.mtr = mtr; e.rw = rw; e.rd = rd; e.res = res;
    e.rdata = rdata; e.err = err; e.chk_res = chk_res;
    return e;
  endfunction

  // memory: acks in the ack_delay-th cycle of a request; -1 never acks
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (mem_req_o) begin
        chk("bus_addr", mem_addr_o, exp_addr);
        chk("bus_we", {31'b0, mem_we_o}, {31'b0, exp_we});
        if (exp_we) chk("bus_wdata", mem_wdata_o, exp_wdata);
        req_total++;
        mem_ack_i   = (busy_cnt == ack_delay);
        mem_rdata_i = (busy_cnt == ack_delay) ? ack_data : 32'h0;
        busy_cnt++;
      end else begin
        busy_cnt    = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
      end
    end
  end

  // monitor: compares MEM/WB one cycle after an unstalled valid instruction
  initial begin
    logic pending;
    exp_t e;
    pending = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        pending = 1'b0;
        continue;
      end
      if (pending) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_memtoreg", {31'b0, MemtoReg_o}, {31'b0, e.mtr});
          chk("wb_regwrite", {31'b0, RegWrite_o}, {31'b0, e.rw});
          chk("wb_rd", {27'b0, RD_o}, {27'b0, e.rd});
          chk("wb_readdata", ReadData_o, e.rdata);
          chk("err", {31'b0, err_o}, {31'b0, e.err});
          if (e.chk_res) chk("wb_result", Result_o, e.res);
        end
      end else begin
        chk("idle_err", {31'b0, err_o}, 32'd0);
        chk("idle_wb", {30'b0, RegWrite_o, MemtoReg_o}, 32'd0);
      end
      pending = tb_valid && !stall_o;
    end
  end

  task automatic clear_inputs();
    MemtoReg_i = 1'b0; RegWrite_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    Result_i = '0; Data_i = '0; RD_i = '0;
  endtask

  task automatic issue(input string name, input logic mtr, input logic rw,
                       input logic mr, input logic mw, input logic [31:0] res,
                       input logic [31:0] dat, input logic [4:0] rd,
                       input int delay, input logic [31:0] rdata,
                       input int exp_stall, input int exp_req, input exp_t e);
    int  stalls;
    int  req0;
    bit  done;
    @(posedge clk_i);
    #1;
    ack_delay = delay; ack_data = rdata;
    exp_addr = res; exp_we = ~mr; exp_wdata = dat;
    req0 = req_total;
    MemtoReg_i = mtr; RegWrite_i = rw; MemRead_i = mr; MemWrite_i = mw;
    Result_i = res; Data_i = dat; RD_i = rd;
    tb_valid = 1'b1;
    sb.push_back(e);
    stalls = 0;
    done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_i);
      if (!stall_o) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) chk({name, "_stall_bound"}, 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    clear_inputs();
    tb_valid = 1'b0;
    @(negedge clk_i);
    chk({name, "_stalls"}, stalls, exp_stall);
    chk({name, "_req_cycles"}, req_total - req0, exp_req);
    $display("txn %s: stalls=%0d req_cycles=%0d", name, stalls, req_total - req0);
  endtask

  initial begin
    #1;
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_outs", {mem_we_o, err_o, MemtoReg_o, RegWrite_o, RD_o}, 32'd0);
    chk("rst_bus", mem_addr_o | mem_wdata_o | ReadData_o | Result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // 1: ALU op passes straight through
    issue("alu", 0, 1, 0, 0, 32'hAA, 32'h0, 5'd5, -1, 32'h0, 0, 0,
          mk(0, 1, 5'd5, 32'hAA, 32'h0, 0, 1));
    // 2: load, ack in 4th BUSY cycle (also the timeout cycle: ack wins)
    issue("load_slow", 1, 1, 1, 0, 32'h100, 32'h0, 5'd3, 3, 32'hDEADBEEF, 4, 4,
          mk(1, 1, 5'd3, 32'h100, 32'hDEADBEEF, 0, 1));
    // 3: store, ack in first BUSY cycle
    issue("store", 0, 0, 0, 1, 32'h40, 32'h12345678, 5'd0, 0, 32'hFFFFFFFF, 1, 1,
          mk(0, 0, 5'd0, 32'h40, 32'h0, 0, 1));
    // 4: misaligned load and store become error bubbles
    issue("misal_load", 1, 1, 1, 0, 32'h102, 32'h0, 5'd7, 0, 32'h0, 0, 0,
          mk(0, 0, 5'd0, 32'h102, 32'h0, 1, 1));
    issue("misal_store", 0, 0, 0, 1, 32'h41, 32'h55, 5'd0, 0, 32'h0, 0, 0,
          mk(0, 0, 5'd0, 32'h41, 32'h0, 1, 1));
    // 5: timeout with no ack, then normal op, then ack on timeout cycle
    issue("timeout", 1, 1, 1, 0, 32'h200, 32'h0, 5'd8, -1, 32'h0, 4, 4,
          mk(0, 0, 5'd0, 32'h0, 32'h0, 1, 0));
    issue("after_to", 0, 1, 0, 0, 32'h1234, 32'h0, 5'd9, -1, 32'h0, 0, 0,
          mk(0, 1, 5'd9, 32'h1234, 32'h0, 0, 1));
    issue("ack_on_to", 1, 1, 1, 0, 32'h204, 32'h0, 5'd10, 3, 32'hCAFEF00D, 4, 4,
          mk(1, 1, 5'd10, 32'h204, 32'hCAFEF00D, 0, 1));
    // read and write both set: treated as a read
    issue("rd_wr_both", 1, 1, 1, 1, 32'h208, 32'h77, 5'd11, 1, 32'h0A0B0C0D, 2, 2,
          mk(1, 1, 5'd11, 32'h208, 32'h0A0B0C0D, 0, 1));

    // 6: asynchronous reset in the middle of a BUSY access
    @(posedge clk_i);
    #1;
    ack_delay = -1; exp_addr = 32'h300; exp_we = 1'b0; exp_wdata = 32'h0;
    MemtoReg_i = 1'b1; RegWrite_i = 1'b1; MemRead_i = 1'b1; Result_i = 32'h300; RD_i = 5'd12;
    repeat (2) @(posedge clk_i);
    #3;
    chk("pre_rst_req", {31'b0, mem_req_o}, 32'd1);
    rst_i = 1'b0;
    clear_inputs();
    #1;
    chk("async_rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("async_rst_outs", {mem_we_o, err_o, MemtoReg_o, RegWrite_o, RD_o, stall_o}, 32'd0);
    chk("async_rst_bus", mem_addr_o | mem_wdata_o | ReadData_o | Result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    issue("load_after_rst", 1, 1, 1, 0, 32'h304, 32'h0, 5'd13, 1, 32'h0BADF00D, 2, 2,
          mk(1, 1, 5'd13, 32'h304, 32'h0BADF00D, 0, 1));

    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
